// File: rtl/div3_seq_ctrl.sv
// Sequential unsigned divide-by-3: walks the dividend MSB-first, CHUNK bits per cycle,
// through one shared remainder/quotient step, with valid/ready on both sides.
module div3_seq_ctrl #(
    parameter int unsigned W     = 64,
    parameter int unsigned CHUNK = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_dividend,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_quot,
    output logic [1:0]     out_rem,
    output logic           busy
);

    localparam int unsigned NSTEP = (W + CHUNK - 1) / CHUNK;
    localparam int unsigned PADW  = NSTEP * CHUNK;
    localparam int unsigned CNTW  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [CNTW-1:0]  LastStep = CNTW'(NSTEP - 1);
    localparam logic [CHUNK+1:0] Three    = (CHUNK + 2)'(3);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [1:0]        rem_q, rem_d;
    logic [W-1:0]      quot_q, quot_d;
    logic [PADW-1:0]   div_q, div_d;

    logic [CHUNK+1:0]  step_v;
    logic [CHUNK-1:0]  step_q;
    logic [1:0]        step_rem;
    logic              accept;

    // rem < 3 keeps step_v < 3*2^CHUNK, so the quotient digit fits in CHUNK bits.
    assign step_v   = {rem_q, div_q[PADW-1 -: CHUNK]};
    assign step_q   = CHUNK'(step_v / Three);
    assign step_rem = 2'(step_v % Three);

    assign in_ready  = (state_q == StIdle) | ((state_q == StDone) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign out_quot  = quot_q;
    assign out_rem   = rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        div_d   = div_q;

        unique case (state_q)
            StIdle: ;
            StRun: begin
                rem_d  = step_rem;
                quot_d = (quot_q << CHUNK) | W'(step_q);
                div_d  = div_q << CHUNK;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LastStep) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Covers both IDLE and the DONE same-edge retire-and-accept path.
        if (accept) begin
            state_d = StRun;
            div_d   = PADW'(in_dividend);
            rem_d   = 2'd0;
            cnt_d   = '0;
            quot_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= 2'd0;
            quot_q  <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: tb/tb_div3_seq_ctrl.sv
// Bench for div3_seq_ctrl: directed vectors with literal expectations plus a
// transaction-level model (d/3, d%3, fixed latency) checked every cycle.
module tb_div3_seq_ctrl;

    localparam int unsigned NSTEP = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_dividend = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_quot;
    logic [1:0]  out_rem;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: cycles left until the result appears, and the pending result.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [63:0] m_q = '0;
    logic [1:0]  m_r = '0;

    div3_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_in_ready();
        return (m_left == 0 && !m_done) || (m_done && out_ready);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
        end else begin
            bit acc, ret;
            acc = in_valid && m_in_ready();
            ret = m_done && out_ready;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end
            if (ret) m_done = 1'b0;
            if (acc) begin
                m_left = NSTEP;
                m_q    = in_dividend / 64'd3;
                m_r    = 2'(in_dividend % 64'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_out_valid", 64'(out_valid), 64'(m_done));
            chk("model_busy", 64'(busy), 64'(m_left > 0));
            chk("model_in_ready", 64'(in_ready), 64'(m_in_ready()));
            chk("rem_not_3", 64'(dut.rem_q == 2'd3), 64'd0);
            if (m_done) begin
                chk("model_quot", out_quot, m_q);
                chk("model_rem", 64'(out_rem), 64'(m_r));
            end
        end
    end

    // Offer d for one cycle; the block must be idle so the next edge accepts it.
    task automatic send(input logic [63:0] d);
        @(posedge clk); #1;
        chk("send_in_ready", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_dividend = d;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_dividend = $urandom;
    endtask

    task automatic wait_valid(input string nm);
        int edges = 0;
        while (!out_valid && edges < 200) begin
            chk({nm, "_run_in_ready"}, 64'(in_ready), 64'd0);
            chk({nm, "_run_busy"}, 64'(busy), 64'd1);
            @(posedge clk); #1;
            edges++;
        end
        chk({nm, "_latency"}, 64'(edges), 64'(NSTEP));
    endtask

    task automatic run_one(input string nm, input logic [63:0] d,
                           input logic [63:0] eq, input logic [1:0] er);
        out_ready = 1'b1;
        send(d);
        wait_valid(nm);
        chk({nm, "_quot"}, out_quot, eq);
        chk({nm, "_rem"}, 64'(out_rem), 64'(er));
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quot", out_quot, 64'd0);
        chk("rst_rem", 64'(out_rem), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk_en = 1'b1;

        run_one("d100", 64'd100, 64'd33, 2'd1);
        run_one("dmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555, 2'd0);
        run_one("dmsb", 64'h8000_0000_0000_0000, 64'h2AAA_AAAA_AAAA_AAAA, 2'd2);
        run_one("d0", 64'd0, 64'd0, 2'd0);
        run_one("d2", 64'd2, 64'd0, 2'd2);

        // Backpressure
        out_ready = 1'b0;
        send(64'd1000);
        wait_valid("bp");
        repeat (10) begin
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_quot", out_quot, 64'd333);
            chk("bp_rem", 64'(out_rem), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_after_valid", 64'(out_valid), 64'd0);
        chk("bp_after_busy", 64'(busy), 64'd0);

        // Back-to-back retire and accept on the same edge
        out_ready = 1'b0;
        send(64'd100);
        wait_valid("b2b_first");
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 64'd7;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_no_bubble_busy", 64'(busy), 64'd1);
        chk("b2b_no_bubble_valid", 64'(out_valid), 64'd0);
        wait_valid("b2b_second");
        chk("b2b_quot", out_quot, 64'd2);
        chk("b2b_rem", 64'(out_rem), 64'd1);
        @(posedge clk); #1;

        // Reset mid-run
        send(64'd12345);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        run_one("d9", 64'd9, 64'd3, 2'd0);

        // Random dividends with random consumer stalls; the model checks each cycle.
        begin
            int sent = 0;
            int cyc  = 0;
            bit acc;
            while (sent < 400 && cyc < 40000) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    sent++;
                    in_valid = 1'b0;
                end
                out_ready = ($urandom_range(0, 3) != 0);
                if (!in_valid && sent < 400 && $urandom_range(0, 1) == 1) begin
                    in_valid = 1'b1;
                    case ($urandom_range(0, 3))
                        0:       in_dividend = 64'($urandom_range(0, 20));
                        1:       in_dividend = {32'hFFFF_FFFF, $urandom};
                        default: in_dividend = {$urandom, $urandom};
                    endcase
                end
            end
            chk("rand_all_sent", 64'(sent), 64'd400);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            cyc = 0;
            while ((out_valid || busy) && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("rand_drained", 64'(out_valid || busy), 64'd0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
